// File: rtl/inst_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// inst_fetch_queue_if
//   Bundles the fetch queue's bus signals: the instruction ROM port, the
//   redirect request, the decode-side valid/ready handshake and the halt flag.
//   Ports (signals):
//     IMEM_ADDR   fetch address to the instruction ROM
//     IMEM_INST   combinational ROM data for IMEM_ADDR
//     REDIR_VALID single-cycle redirect request
//     REDIR_PC    redirect target (low two bits ignored)
//     OUT_VALID   queue head holds a valid entry
//     OUT_READY   consumer accepts the head this cycle
//     OUT_INST    head instruction (0 when not valid)
//     OUT_PC      head PC (0 when not valid)
//     HALTED      fetch stopped after EBREAK
//   Modports: slave = the fetch queue itself, master = its environment.
// ---------------------------------------------------------------------------
interface inst_fetch_queue_if;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_INST;
  logic        REDIR_VALID;
  logic [31:0] REDIR_PC;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_INST;
  logic [31:0] OUT_PC;
  logic        HALTED;

  modport slave (
    output IMEM_ADDR,
    input  IMEM_INST,
    input  REDIR_VALID,
    input  REDIR_PC,
    output OUT_VALID,
    input  OUT_READY,
    output OUT_INST,
    output OUT_PC,
    output HALTED
  );

  modport master (
    input  IMEM_ADDR,
    output IMEM_INST,
    output REDIR_VALID,
    output REDIR_PC,
    input  OUT_VALID,
    output OUT_READY,
    input  OUT_INST,
    input  OUT_PC,
    input  HALTED
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// ---------------------------------------------------------------------------
// inst_fetch_queue
//   Fetch stage ahead of a single-cycle datapath. Owns the PC, addresses a
//   combinational instruction ROM and buffers {PC, INST} pairs in a DEPTH-entry
//   FIFO that feeds decode through a valid/ready handshake. A redirect flushes
//   the FIFO and reloads the PC; fetching stops after an EBREAK is enqueued
//   until the next redirect or reset.
//   Parameters:
//     DEPTH    FIFO entries, power of two, >= 2
//     RESET_PC PC loaded at reset, word aligned
//   Ports:
//     CLK  clock, rising edge
//     RST  asynchronous active-low reset
//     bus  inst_fetch_queue_if.slave (ROM port, redirect, output handshake, HALTED)
// ---------------------------------------------------------------------------
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  CLK,
  input  logic                  RST,
  inst_fetch_queue_if.slave     bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
  localparam logic [31:0]   EBREAK_C = 32'h0010_0073;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t         state_r, state_s;
  logic [31:0]    pc_r, pc_s;
  logic [PW-1:0]  rd_ptr_r, rd_ptr_s;
  logic [PW-1:0]  wr_ptr_r, wr_ptr_s;
  logic [CW-1:0]  count_r, count_s;
  logic [31:0]    mem_pc_r   [DEPTH];
  logic [31:0]    mem_inst_r [DEPTH];

  logic           out_valid_s;
  logic           handshake_s;
  logic           pop_s;
  logic           push_s;
  logic [31:0]    redir_pc_s;

  assign out_valid_s = (count_r != {CW{1'b0}});
  assign handshake_s = out_valid_s & bus.OUT_READY;
  // A redirect discards any concurrent pop along with the rest of the FIFO.
  assign pop_s       = handshake_s & ~bus.REDIR_VALID;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_s      = (state_r == ST_RUN) & ~bus.REDIR_VALID &
                       ((count_r < FULL_C) | handshake_s);
  assign redir_pc_s  = bus.REDIR_PC & ~32'h0000_0003;

  // Next-state logic for the run/halt FSM.
  always_comb begin
    state_s = state_r;
    if (bus.REDIR_VALID) begin
      state_s = ST_RUN;
    end else if (push_s && (bus.IMEM_INST == EBREAK_C)) begin
      state_s = ST_HALT;
    end else begin
      state_s = state_r;
    end
  end

  // Next PC: redirect target, sequential increment on push, otherwise hold.
  always_comb begin
    pc_s = pc_r;
    if (bus.REDIR_VALID) begin
      pc_s = redir_pc_s;
    end else if (push_s) begin
      pc_s = pc_r + 32'd4;
    end else begin
      pc_s = pc_r;
    end
  end

  // Next FIFO pointers and occupancy; a redirect flushes everything.
  always_comb begin
    rd_ptr_s = rd_ptr_r;
    wr_ptr_s = wr_ptr_r;
    count_s  = count_r;
    if (bus.REDIR_VALID) begin
      rd_ptr_s = {PW{1'b0}};
      wr_ptr_s = {PW{1'b0}};
      count_s  = {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_s = wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_s = rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_s = count_r + CW'(1);
        2'b01:   count_s = count_r - CW'(1);
        default: count_s = count_r;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r  <= ST_RUN;
      pc_r     <= RESET_PC;
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      state_r  <= state_s;
      pc_r     <= pc_s;
      rd_ptr_r <= rd_ptr_s;
      wr_ptr_r <= wr_ptr_s;
      count_r  <= count_s;
    end
  end

  // FIFO storage; cleared on reset so no stale data is ever observable.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_r[i]   <= 32'h0000_0000;
        mem_inst_r[i] <= 32'h0000_0000;
      end
    end else if (push_s) begin
      mem_pc_r[wr_ptr_r]   <= pc_r;
      mem_inst_r[wr_ptr_r] <= bus.IMEM_INST;
    end
  end

  assign bus.IMEM_ADDR = pc_r;
  assign bus.OUT_VALID = out_valid_s;
  assign bus.OUT_PC    = out_valid_s ? mem_pc_r[rd_ptr_r]   : 32'h0000_0000;
  assign bus.OUT_INST  = out_valid_s ? mem_inst_r[rd_ptr_r] : 32'h0000_0000;
  assign bus.HALTED    = (state_r == ST_HALT);

endmodule

// File: tb/tb_inst_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_queue
//   Directed bench for inst_fetch_queue. Instance u_dut0 uses RESET_PC=0,
//   instance u_dut1 uses RESET_PC=FFFFFFF8 for the wrap and reset cases.
//   The ROM returns word index (addr>>2), optionally EBREAK at one address.
// ---------------------------------------------------------------------------
module tb_inst_fetch_queue;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        CLK = 1'b0;
  logic        RST;
  logic        RST2;
  logic        ebreak_en;
  logic [31:0] ebreak_addr;
  int          vectors    = 0;
  int          miscompares = 0;

  inst_fetch_queue_if bus0 ();
  inst_fetch_queue_if bus1 ();

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut0 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus0)
  );

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut1 (
    .CLK (CLK),
    .RST (RST2),
    .bus (bus1)
  );

  always #5 CLK = ~CLK;

  assign bus0.IMEM_INST = (ebreak_en && (bus0.IMEM_ADDR == ebreak_addr)) ?
                          EBREAK : {2'b00, bus0.IMEM_ADDR[31:2]};
  assign bus1.IMEM_INST = {2'b00, bus1.IMEM_ADDR[31:2]};

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    RST = 1'b0;
    bus0.REDIR_VALID = 1'b0;
    bus0.REDIR_PC    = 32'h0;
    bus0.OUT_READY   = ready;
    repeat (2) tick();
    RST = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({bus0.OUT_VALID, bus0.OUT_PC, bus0.OUT_INST, bus0.HALTED} !== {1'b0, 32'h0, 32'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b pc=%h inst=%h h=%b, want all 0",
               bus0.OUT_VALID, bus0.OUT_PC, bus0.OUT_INST, bus0.HALTED);
    end
    vectors++;
    if (bus0.IMEM_ADDR !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_addr0: got %h want 00000000", bus0.IMEM_ADDR);
    end
    vectors++;
    if (bus1.IMEM_ADDR !== 32'hFFFF_FFF8) begin
      miscompares++;
      $display("FAIL reset_addr1: got %h want fffffff8", bus1.IMEM_ADDR);
    end
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      vectors++;
      if ({bus0.OUT_VALID, bus0.OUT_PC, bus0.OUT_INST} !== {1'b1, 32'(4 * i), 32'(i)}) begin
        miscompares++;
        $display("FAIL stream[%0d]: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                 i, bus0.OUT_VALID, bus0.OUT_PC, bus0.OUT_INST, 32'(4 * i), 32'(i));
      end
    end
  endtask

  task automatic test_backpressure_and_full();
    logic [31:0] exp_addr;
    do_reset(1'b0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_addr = (k < 4) ? 32'(4 * k) : 32'h0000_0010;
      vectors++;
      if (bus0.IMEM_ADDR !== exp_addr) begin
        miscompares++;
        $display("FAIL stall_addr[%0d]: got %h want %h", k, bus0.IMEM_ADDR, exp_addr);
      end
      vectors++;
      if ({bus0.OUT_VALID, bus0.OUT_PC} !== {1'b1, 32'h0}) begin
        miscompares++;
        $display("FAIL stall_head[%0d]: got v=%b pc=%h want v=1 pc=0", k, bus0.OUT_VALID, bus0.OUT_PC);
      end
    end
    bus0.OUT_READY = 1'b1;
    // Full FIFO with consumer ready: head and PC advance together every edge.
    for (int j = 0; j < 8; j++) begin
      vectors++;
      if ({bus0.OUT_VALID, bus0.OUT_PC, bus0.OUT_INST} !== {1'b1, 32'(4 * j), 32'(j)}) begin
        miscompares++;
        $display("FAIL drain[%0d]: got v=%b pc=%h inst=%h want pc=%h inst=%h",
                 j, bus0.OUT_VALID, bus0.OUT_PC, bus0.OUT_INST, 32'(4 * j), 32'(j));
      end
      vectors++;
      if (bus0.IMEM_ADDR !== 32'(16 + 4 * j)) begin
        miscompares++;
        $display("FAIL full_addr[%0d]: got %h want %h", j, bus0.IMEM_ADDR, 32'(16 + 4 * j));
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    repeat (4) tick();
    bus0.REDIR_VALID = 1'b1;
    bus0.REDIR_PC    = 32'h0000_0103;
    bus0.OUT_READY   = 1'b1;
    tick();
    bus0.REDIR_VALID = 1'b0;
    vectors++;
    if ({bus0.OUT_VALID, bus0.OUT_PC, bus0.IMEM_ADDR} !== {1'b0, 32'h0, 32'h0000_0100}) begin
      miscompares++;
      $display("FAIL redir_bubble: got v=%b pc=%h addr=%h want v=0 pc=0 addr=00000100",
               bus0.OUT_VALID, bus0.OUT_PC, bus0.IMEM_ADDR);
    end
    for (int j = 0; j < 4; j++) begin
      tick();
      vectors++;
      if ({bus0.OUT_VALID, bus0.OUT_PC, bus0.OUT_INST} !== {1'b1, 32'(256 + 4 * j), 32'(64 + j)}) begin
        miscompares++;
        $display("FAIL redir_seq[%0d]: got v=%b pc=%h inst=%h want pc=%h inst=%h",
                 j, bus0.OUT_VALID, bus0.OUT_PC, bus0.OUT_INST, 32'(256 + 4 * j), 32'(64 + j));
      end
    end
    // Two redirects on consecutive edges: the second target wins.
    bus0.REDIR_VALID = 1'b1;
    bus0.REDIR_PC    = 32'h0000_0200;
    tick();
    vectors++;
    if (bus0.OUT_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_first_flush: got v=%b want 0", bus0.OUT_VALID);
    end
    bus0.REDIR_PC = 32'h0000_0300;
    tick();
    bus0.REDIR_VALID = 1'b0;
    vectors++;
    if ({bus0.OUT_VALID, bus0.IMEM_ADDR} !== {1'b0, 32'h0000_0300}) begin
      miscompares++;
      $display("FAIL b2b_bubble: got v=%b addr=%h want v=0 addr=00000300", bus0.OUT_VALID, bus0.IMEM_ADDR);
    end
    tick();
    vectors++;
    if ({bus0.OUT_VALID, bus0.OUT_PC, bus0.OUT_INST} !== {1'b1, 32'h0000_0300, 32'h0000_00C0}) begin
      miscompares++;
      $display("FAIL b2b_target: got v=%b pc=%h inst=%h want pc=00000300 inst=000000c0",
               bus0.OUT_VALID, bus0.OUT_PC, bus0.OUT_INST);
    end
    tick();
    vectors++;
    if ({bus0.OUT_VALID, bus0.OUT_PC} !== {1'b1, 32'h0000_0304}) begin
      miscompares++;
      $display("FAIL b2b_next: got v=%b pc=%h want pc=00000304", bus0.OUT_VALID, bus0.OUT_PC);
    end
  endtask

  task automatic test_ebreak();
    logic [31:0] exp_inst [3];
    exp_inst[0] = 32'h0;
    exp_inst[1] = 32'h1;
    exp_inst[2] = EBREAK;
    ebreak_en   = 1'b1;
    ebreak_addr = 32'h0000_0008;
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({bus0.OUT_VALID, bus0.OUT_PC, bus0.OUT_INST, bus0.HALTED, bus0.IMEM_ADDR} !==
          {1'b1, 32'(4 * i), exp_inst[i], (i == 2), 32'(4 * i + 4)}) begin
        miscompares++;
        $display("FAIL ebreak_seq[%0d]: got v=%b pc=%h inst=%h h=%b addr=%h want pc=%h inst=%h h=%b addr=%h",
                 i, bus0.OUT_VALID, bus0.OUT_PC, bus0.OUT_INST, bus0.HALTED, bus0.IMEM_ADDR,
                 32'(4 * i), exp_inst[i], (i == 2), 32'(4 * i + 4));
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if ({bus0.OUT_VALID, bus0.HALTED, bus0.IMEM_ADDR} !== {1'b0, 1'b1, 32'h0000_000C}) begin
        miscompares++;
        $display("FAIL halted[%0d]: got v=%b h=%b addr=%h want v=0 h=1 addr=0000000c",
                 i, bus0.OUT_VALID, bus0.HALTED, bus0.IMEM_ADDR);
      end
    end
    bus0.REDIR_VALID = 1'b1;
    bus0.REDIR_PC    = 32'h0000_0040;
    tick();
    bus0.REDIR_VALID = 1'b0;
    vectors++;
    if ({bus0.OUT_VALID, bus0.HALTED, bus0.IMEM_ADDR} !== {1'b0, 1'b0, 32'h0000_0040}) begin
      miscompares++;
      $display("FAIL resume_redir: got v=%b h=%b addr=%h want v=0 h=0 addr=00000040",
               bus0.OUT_VALID, bus0.HALTED, bus0.IMEM_ADDR);
    end
    tick();
    vectors++;
    if ({bus0.OUT_VALID, bus0.OUT_PC, bus0.OUT_INST, bus0.IMEM_ADDR} !==
        {1'b1, 32'h0000_0040, 32'h0000_0010, 32'h0000_0044}) begin
      miscompares++;
      $display("FAIL resume_fetch: got v=%b pc=%h inst=%h addr=%h want pc=00000040 inst=00000010 addr=00000044",
               bus0.OUT_VALID, bus0.OUT_PC, bus0.OUT_INST, bus0.IMEM_ADDR);
    end
    ebreak_en = 1'b0;
  endtask

  task automatic test_wrap_and_reset();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'hFFFF_FFF8;
    exp_pc[1] = 32'hFFFF_FFFC;
    exp_pc[2] = 32'h0000_0000;
    exp_pc[3] = 32'h0000_0004;
    RST2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if ({bus1.OUT_VALID, bus1.OUT_PC, bus1.OUT_INST} !== {1'b1, exp_pc[i], {2'b00, exp_pc[i][31:2]}}) begin
        miscompares++;
        $display("FAIL wrap[%0d]: got v=%b pc=%h inst=%h want pc=%h inst=%h",
                 i, bus1.OUT_VALID, bus1.OUT_PC, bus1.OUT_INST, exp_pc[i], {2'b00, exp_pc[i][31:2]});
      end
    end
    #2;
    RST2 = 1'b0;
    #1;
    vectors++;
    if ({bus1.OUT_VALID, bus1.OUT_PC, bus1.IMEM_ADDR} !== {1'b0, 32'h0, 32'hFFFF_FFF8}) begin
      miscompares++;
      $display("FAIL async_reset: got v=%b pc=%h addr=%h want v=0 pc=0 addr=fffffff8",
               bus1.OUT_VALID, bus1.OUT_PC, bus1.IMEM_ADDR);
    end
    tick();
    RST2 = 1'b1;
    tick();
    vectors++;
    if ({bus1.OUT_VALID, bus1.OUT_PC, bus1.IMEM_ADDR} !== {1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC}) begin
      miscompares++;
      $display("FAIL restart: got v=%b pc=%h addr=%h want v=1 pc=fffffff8 addr=fffffffc",
               bus1.OUT_VALID, bus1.OUT_PC, bus1.IMEM_ADDR);
    end
  endtask

  initial begin
    RST              = 1'b0;
    RST2             = 1'b0;
    ebreak_en        = 1'b0;
    ebreak_addr      = 32'h0;
    bus0.REDIR_VALID = 1'b0;
    bus0.REDIR_PC    = 32'h0;
    bus0.OUT_READY   = 1'b0;
    bus1.REDIR_VALID = 1'b0;
    bus1.REDIR_PC    = 32'h0;
    bus1.OUT_READY   = 1'b1;

    test_reset();
    test_stream();
    test_backpressure_and_full();
    test_redirect();
    test_ebreak();
    test_wrap_and_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
